// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the programmable instruction memory
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Selects what fetch_instr presents: reset zero, the fill word after a fault, or RAM data
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_FILL = 2'd1,
        SRC_RAM  = 2'd2
    } instr_src_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - simple dual-port synchronous RAM, one write port and one registered read port
module imem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write port; the array is deliberately not reset, the controller clears it instead
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; rdata holds its value when no read is issued
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_prog_ctrl.sv
// rtl/imem_prog_ctrl.sv - run-time programmable instruction memory with clear, load and fetch paths
module imem_prog_ctrl
    import imem_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] FILL_WORD = NOP_INSTR,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_instr,
    output logic              fetch_valid,
    output logic              fetch_fault,
    output logic              fetch_stall,
    input  logic              ld_start,
    input  logic [AW-1:0]     ld_base,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t      state_q;
    state_t      state_d;
    logic [AW-1:0] clr_ptr_q;
    logic [AW:0]   wr_ptr_q;
    instr_src_t  src_q;
    logic        valid_q;
    logic        fault_q;
    logic        done_q;
    logic        err_q;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_rdata;

    logic fetch_ok;
    logic fetch_bad;
    logic beat;
    logic wr_full;

    // Request decode: only RUN serves fetches; a fault is a misaligned or out-of-range byte address
    always_comb begin
        fetch_ok  = (state_q == RUN) && fetch_req;
        fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (AW + 2)) != '0);
        beat      = (state_q == LOAD) && ld_valid;
        wr_full   = wr_ptr_q[AW];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-derived handshake outputs
    always_comb begin
        state_d     = state_q;
        ld_ready    = 1'b0;
        fetch_stall = 1'b1;
        case (state_q)
            CLEAR: begin
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                fetch_stall = 1'b0;
                if (ld_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (beat && ld_last) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Write-port mux: CLEAR sweeps the fill word, LOAD writes beats that still fit
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_ptr_q;
        ram_wdata = FILL_WORD;
        if (state_q == CLEAR) begin
            ram_we = 1'b1;
        end else if (beat && !wr_full) begin
            ram_we    = 1'b1;
            ram_waddr = wr_ptr_q[AW-1:0];
            ram_wdata = ld_data;
        end
    end

    // Read port is only touched for good fetches; faults never access the array
    always_comb begin
        ram_re    = fetch_ok && !fetch_bad;
        ram_raddr = fetch_addr[AW+1:2];
    end

    // Pointers, fetch response flags and loader status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_ptr_q <= '0;
            wr_ptr_q  <= '0;
            src_q     <= SRC_ZERO;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == CLEAR) begin
                clr_ptr_q <= clr_ptr_q + 1'b1;
            end

            valid_q <= fetch_ok;
            fault_q <= fetch_ok && fetch_bad;
            if (fetch_ok) begin
                src_q <= fetch_bad ? SRC_FILL : SRC_RAM;
            end

            done_q <= beat && ld_last;

            if ((state_q == RUN) && ld_start) begin
                wr_ptr_q <= {1'b0, ld_base};
                err_q    <= 1'b0;
            end else if (beat) begin
                if (wr_full) begin
                    err_q <= 1'b1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
        end
    end

    // Output selection; fetch_instr keeps its last value between requests
    always_comb begin
        case (src_q)
            SRC_ZERO: fetch_instr = '0;
            SRC_FILL: fetch_instr = FILL_WORD;
            default:  fetch_instr = ram_rdata;
        endcase
        fetch_valid = valid_q;
        fetch_fault = fault_q;
        ld_done     = done_q;
        ld_err      = err_q;
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule
